gencol_lanes: RTL
=================

# gencol_lanes

Multi-lane, flow-controlled Toeplitz column generator; successor to the single-stride column generator in the privacy-amplification hash path. Loads one Toeplitz seed (first column plus first row), then streams LANES consecutive matrix columns per accepted beat over a valid/ready interface to the downstream matrix-vector XOR stage. It adds backpressure, a one-shot or continuous (auto-rewind) mode, a last-beat marker and a column index, so the consumer can stall without losing position.

## Interface
- N, 256, number of matrix columns (row length); N % LANES == 0 required
- L, 128, number of matrix rows (column length)
- LANES, 4, columns emitted per beat; 1 <= LANES <= N
- clk  in  1  clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- load  in  1  capture seed and mode, restart at column 0
- cont  in  1  mode sampled with load: 1 = continuous, 0 = one-shot
- row0  in  N  first-row seed (rrow0 convention: bit 0 feeds column 1)
- col0  in  L  first-column seed
- col_ready  in  1  downstream accepts beat
- col_valid  out  1  col_data valid
- col_data  out  LANES*L  lane k at bits [k*L +: L] = column col_idx+k
- col_last  out  1  current beat holds column N-1
- col_idx  out  $clog2(N) (min 1)  index of lane-0 column
- busy  out  1  state is RUN
- frame_cnt  out  16  completed matrices (see Configuration)

## Operation
- Seed vector S = {row0, col0}, width N+L. Column j = S[j+L-1 : j], j = 0..N-1.
- Internal: seed copy (N+L bits, for rewind), working shift register W (N+L bits), column counter, mode bit, 3-state FSM IDLE / RUN / DONE.
- Lane k of col_data = W[k+L-1 : k]; beat accepted when col_valid && col_ready; on acceptance W shifts right by LANES (zero fill), col_idx += LANES.
- IDLE: col_valid=0. load -> capture S into seed copy and W, mode <= cont, col_idx <= 0, go RUN.
- RUN: col_valid=1. Accepted beat with col_idx == N-LANES (col_last=1): cont=1 -> W <= seed copy, col_idx <= 0, frame_cnt++, stay RUN; cont=0 -> frame_cnt++, go DONE.
- DONE: col_valid=0, outputs hold last data; load -> RUN as from IDLE.
- load in any state has priority over a simultaneous accept: that beat is discarded (no frame_cnt increment); new seed visible next cycle.
- col_ready low: W, col_idx, col_data, col_last all hold (AXI-stream stability rule; valid never drops while RUN unless load or reset).
- col_last = (state == RUN) && (col_idx == N-LANES).
- frame_cnt wraps 0xFFFF -> 0.
- Reset: state IDLE, W/seed copy/col_data = 0, col_valid=0, col_last=0, col_idx=0, busy=0, frame_cnt=0. Reset mid-stream aborts with no further beats; reset overrides load.

## Timing
- load sampled at edge t -> col_valid=1 with column 0 from t+1.
- One beat per cycle sustained with col_ready held high; N/LANES beats per matrix.
- Continuous mode: column 0 of next frame valid the cycle after last beat accepted; no bubble.
- One-shot: col_valid low the cycle after last beat accepted.
- All outputs registered; no combinational path from col_ready or load to any output.

## Configuration
- GENCOL_FRAMECNT_EN defined: 16-bit frame counter implemented as above.
- Not defined: counter logic omitted, frame_cnt tied to 16'h0000; all other behaviour identical.

## Test plan
- N=8, L=4, LANES=2, col0=4'b1010, row0=8'b11001100, cont=0, col_ready=1: beats 0x5A (idx 0), then idx 2, 4, then 0x93 at idx 6 with col_last=1; col_valid low next cycle; frame_cnt=1.
- Same seed, col_ready toggled 1,0,0,1,...: each beat held stable while ready low; same 4-beat sequence, no duplicates or gaps.
- Same seed, cont=1, 10 beats accepted: beat 4 repeats 0x5A at idx 0; beat 8 0x5A again; frame_cnt=2 after beat 7.
- load asserted at idx 4 with new seed col0=4'b0001, row0=8'h00 while col_ready=1: next beat idx 0, data 0x01; frame_cnt unchanged.
- reset_n low for one cycle during RUN: next cycle col_valid=0, col_idx=0, frame_cnt=0; no beat until next load.
- LANES=1, N=8: 8 beats, beat j equals S[j+3:j], col_last only on j=7; build without GENCOL_FRAMECNT_EN gives frame_cnt=0 throughout.

Source files
------------

// File: rtl/gencol_lanes_if.sv
`default_nettype none
// ============================================================================
// Module      : gencol_lanes_if
// Description : Column-stream bus between the Toeplitz column generator
//               (master) and the matrix-vector XOR stage (slave).
//               col_valid / col_ready : beat handshake
//               col_data              : LANES columns, lane k at [k*L +: L]
//               col_last              : beat carries column N-1
//               col_idx               : column index of lane 0
// Revision    : 1.0 - initial release
// ============================================================================
interface gencol_lanes_if #(
    parameter int N     = 256,
    parameter int L     = 128,
    parameter int LANES = 4
);
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    logic                  col_valid;
    logic                  col_ready;
    logic [LANES*L-1:0]    col_data;
    logic                  col_last;
    logic [IDXW-1:0]       col_idx;

    modport master (
        output col_valid,
        output col_data,
        output col_last,
        output col_idx,
        input  col_ready
    );

    modport slave (
        input  col_valid,
        input  col_data,
        input  col_last,
        input  col_idx,
        output col_ready
    );
endinterface
`default_nettype wire

// File: rtl/gencol_lanes.sv
`default_nettype none
// ============================================================================
// Module      : gencol_lanes
// Description : Multi-lane flow-controlled Toeplitz column generator. A seed
//               S = {row0, col0} is loaded; column j = S[j+L-1:j]. Each
//               accepted beat carries LANES consecutive columns.
// Ports       : clk, reset_n (synchronous, active low)
//               load/cont     : capture seed and mode (1 = auto-rewind)
//               row0/col0     : Toeplitz first row / first column
//               col           : column stream (gencol_lanes_if master)
//               busy          : generator is streaming
//               frame_cnt     : completed matrices
// Options     : GENCOL_FRAMECNT_EN - implements the 16-bit frame counter;
//               when undefined frame_cnt is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module gencol_lanes #(
    parameter int N     = 256,
    parameter int L     = 128,
    parameter int LANES = 4
) (
    input  wire              clk,
    input  wire              reset_n,
    input  wire              load,
    input  wire              cont,
    input  wire [N-1:0]      row0,
    input  wire [L-1:0]      col0,
    gencol_lanes_if.master   col,
    output logic             busy,
    output logic [15:0]      frame_cnt
);
    localparam int               IDXW     = (N > 1) ? $clog2(N) : 1;
    localparam int               SW       = N + L;
    localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(N - LANES);
    localparam logic [IDXW-1:0]  STEP     = IDXW'(LANES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   w_q, w_d;
    logic [SW-1:0]   seed_q, seed_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            mode_q, mode_d;

    logic            at_last;
    logic            accept;

    assign at_last = (idx_q == LAST_IDX);
    assign accept  = (state_q == S_RUN) && col.col_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            w_q     <= '0;
            seed_q  <= '0;
            idx_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            seed_q  <= seed_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        seed_d  = seed_q;
        idx_d   = idx_q;
        mode_d  = mode_q;
        if (load) begin
            // load wins over a simultaneous accept: the shown beat is dropped
            seed_d  = {row0, col0};
            w_d     = {row0, col0};
            mode_d  = cont;
            idx_d   = '0;
            state_d = S_RUN;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (accept) begin
                        if (at_last) begin
                            if (mode_q) begin
                                // rewind without a bubble
                                w_d   = seed_q;
                                idx_d = '0;
                            end else begin
                                // one-shot: keep last data on the bus, drop valid
                                state_d = S_DONE;
                            end
                        end else begin
                            w_d   = w_q >> LANES;
                            idx_d = idx_q + STEP;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Lane k is the L-bit window starting at bit k of the working register
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign col.col_data[k*L +: L] = w_q[k +: L];
    end

    assign col.col_valid = (state_q == S_RUN);
    assign col.col_last  = (state_q == S_RUN) && at_last;
    assign col.col_idx   = idx_q;
    assign busy          = (state_q == S_RUN);

`ifdef GENCOL_FRAMECNT_EN
    logic        frame_done;
    logic [15:0] fcnt_q;

    assign frame_done = !load && accept && at_last;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fcnt_q <= 16'h0000;
        end else if (frame_done) begin
            fcnt_q <= fcnt_q + 16'd1;
        end
    end

    assign frame_cnt = fcnt_q;
`else
    assign frame_cnt = 16'h0000;
`endif

endmodule
`default_nettype wire
